seg_scan_decoder: RTL and testbench

- Decodes multiplexed 7-segment display drive back into BCD digits, per digit position.
- Inverse end of the team's BCD-to-segment encoding. Used to check display output in-system and to read external segment-driven displays.
- Samples the segment and digit-select lines and waits for them to be stable.
- Commits the decoded value per digit and pulses a flag once every digit position has been refreshed.

---
 rtl/seg_scan_decoder.sv | 153 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from multiplexed 7-segment drive lines.
// Each digit is committed once per stable period; frame_valid pulses when every digit has been refreshed.
module seg_digit_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [3:0] val,
    input  logic       dp,
    input  logic       bad,
    output logic [3:0] bcd,
    output logic       dot,
    output logic       err
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            dot <= 1'b0;
            err <= 1'b0;
        end else if (wr) begin
            bcd <= val;
            dot <= dp;
            err <= bad;
        end
    end
endmodule

module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     dot_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  frame_valid,
    output logic                  sel_err
);
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    logic [7:0]        seg_m, seg_s;
    logic [DIGITS-1:0] sel_m, sel_s;
    logic [3:0]        cnt;
    logic [DIGITS-1:0] seen, seen_nxt;
    state_t            state, state_n;
    logic              commit, onehot;
    logic [3:0]        dec_val;
    logic              dec_bad;

    // cnt tracks how many consecutive cycles S has held its current value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '0;
            seg_s <= '0;
            sel_m <= '0;
            sel_s <= '0;
            cnt   <= '0;
        end else begin
            seg_m <= seg_in;
            seg_s <= seg_m;
            sel_m <= dig_sel;
            sel_s <= sel_m;
            if ({sel_m, seg_m} != {sel_s, seg_s})
                cnt <= 4'd1;
            else if (cnt != STABLE)
                cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            IDLE:   if (sel_s != '0) state_n = SETTLE;
            SETTLE: begin
                if (sel_s == '0) state_n = IDLE;
                else if (cnt == STABLE) begin
                    commit  = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // cnt==1 in HOLD means S just changed
                if (sel_s == '0)     state_n = IDLE;
                else if (cnt == 4'd1) state_n = SETTLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        dec_bad = 1'b0;
        case (seg_s[7:1])
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_bad = 1'b1;
            end
        endcase
    end

    assign onehot   = (sel_s != '0) && ((sel_s & (sel_s - DIGITS'(1))) == '0);
    assign seen_nxt = seen | ((commit && onehot) ? sel_s : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen        <= '0;
            frame_valid <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            sel_err     <= commit && !onehot;
            frame_valid <= 1'b0;
            if (&seen_nxt) begin
                seen        <= '0;
                frame_valid <= 1'b1;
            end else begin
                seen <= seen_nxt;
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_slot
        seg_digit_slot u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (commit && onehot && sel_s[i]),
            .val   (dec_val),
            .dp    (seg_s[0]),
            .bad   (dec_bad),
            .bcd   (bcd_out[4*i +: 4]),
            .dot   (dot_out[i]),
            .err   (err_out[i])
        );
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: reset, scan, glitch, invalid, multi-hot and long-hold scenarios.
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] bcd_out;
    logic [3:0]  dot_out, err_out;
    logic        frame_valid, sel_err;

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    int se_cnt = 0;

    localparam logic [7:0] P1 = 8'h60, P2 = 8'hDA, P3 = 8'hF2, P4 = 8'h66, P5 = 8'hB6;
    localparam logic [7:0] P6 = 8'hBE, P7 = 8'hE0, P8 = 8'hFE, P9 = 8'hF6, P0 = 8'hFC;

    seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
        .bcd_out(bcd_out), .dot_out(dot_out), .err_out(err_out),
        .frame_valid(frame_valid), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (sel_err === 1'b1) se_cnt++;
    end

    // drive at a negedge, then wait n negedges
    task automatic step(input logic [3:0] sel, input logic [7:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        int fv0;
        step(4'b0001, P9, 8);
        step(4'b0010, P9, 8);
        step(4'b0100, P3, 3);
        tests++;
        if (bcd_out[7:0] !== 8'h99) begin
            fails++; $display("FAIL pre_reset bcd got %h want 99", bcd_out[7:0]);
        end
        #2 rst_n = 1'b0;
        dig_sel = '0;
        seg_in  = '0;
        #1;
        tests++;
        if ({bcd_out, dot_out, err_out, frame_valid, sel_err} !== '0) begin
            fails++; $display("FAIL async_reset got bcd=%h dot=%b err=%b fv=%b se=%b want all 0",
                              bcd_out, dot_out, err_out, frame_valid, sel_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fv0 = fv_cnt;
        step(4'b0001, P8, 8);
        step(4'b0010, P8, 8);
        step(4'b0100, P8, 8);
        step(4'b0000, 8'h00, 8);
        tests++;
        if (fv_cnt - fv0 !== 0) begin
            fails++; $display("FAIL reset_no_frame got %0d pulses want 0", fv_cnt - fv0);
        end
        tests++;
        if (bcd_out !== 16'h0888) begin
            fails++; $display("FAIL reset_partial_bcd got %h want 0888", bcd_out);
        end
    endtask

    task automatic test_scan;
        int fv0;
        fv0 = fv_cnt;
        step(4'b0001, P1, 8);
        step(4'b0010, P2 | 8'h01, 8);
        step(4'b0100, P3, 8);
        dig_sel = 4'b1000;
        seg_in  = P4;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tests++;
            if (frame_valid !== (k == 6) || bcd_out[15:12] !== (k >= 6 ? 4'd4 : 4'd0)) begin
                fails++; $display("FAIL scan_timing k=%0d got fv=%b nib3=%h want fv=%b nib3=%h",
                                  k, frame_valid, bcd_out[15:12], (k == 6), (k >= 6 ? 4'd4 : 4'd0));
            end
        end
        step(4'b0000, 8'h00, 8);
        tests++;
        if (bcd_out !== 16'h4321 || dot_out !== 4'b0010 || err_out !== 4'b0000) begin
            fails++; $display("FAIL scan_values got bcd=%h dot=%b err=%b want 4321 0010 0000",
                              bcd_out, dot_out, err_out);
        end
        tests++;
        if (fv_cnt - fv0 !== 1) begin
            fails++; $display("FAIL scan_frame_count got %0d want 1", fv_cnt - fv0);
        end
    endtask

    task automatic test_glitch;
        step(4'b0001, P5, 3);
        step(4'b0000, 8'h00, 8);
        tests++;
        if (bcd_out[3:0] !== 4'd1) begin
            fails++; $display("FAIL glitch_short got %h want 1", bcd_out[3:0]);
        end
        step(4'b0001, P5, 4);
        step(4'b0000, 8'h00, 8);
        tests++;
        if (bcd_out[3:0] !== 4'd5 || dot_out[0] !== 1'b0) begin
            fails++; $display("FAIL glitch_commit got nib0=%h dot0=%b want 5 0", bcd_out[3:0], dot_out[0]);
        end
    endtask

    task automatic test_invalid;
        step(4'b0100, 8'h02, 8);
        tests++;
        if (bcd_out[11:8] !== 4'hF || err_out[2] !== 1'b1) begin
            fails++; $display("FAIL invalid got nib2=%h err2=%b want F 1", bcd_out[11:8], err_out[2]);
        end
        step(4'b0100, P7, 8);
        step(4'b0000, 8'h00, 8);
        tests++;
        if (bcd_out[11:8] !== 4'd7 || err_out !== 4'b0000) begin
            fails++; $display("FAIL invalid_recover got nib2=%h err=%b want 7 0000", bcd_out[11:8], err_out);
        end
    endtask

    task automatic test_multihot;
        int fv0, se0;
        tests++;
        if (se_cnt !== 0) begin
            fails++; $display("FAIL no_spurious_sel_err got %0d want 0", se_cnt);
        end
        se0 = se_cnt;
        step(4'b0011, P0, 10);
        step(4'b0000, 8'h00, 8);
        tests++;
        if (se_cnt - se0 !== 1) begin
            fails++; $display("FAIL multihot_pulse got %0d want 1", se_cnt - se0);
        end
        tests++;
        if (bcd_out !== 16'h4725 || dot_out !== 4'b0010) begin
            fails++; $display("FAIL multihot_outputs got bcd=%h dot=%b want 4725 0010", bcd_out, dot_out);
        end
        // seen holds digits 0 and 2; digit 3 alone must not finish the frame
        fv0 = fv_cnt;
        step(4'b1000, P6, 8);
        tests++;
        if (fv_cnt - fv0 !== 0) begin
            fails++; $display("FAIL multihot_seen got %0d pulses want 0", fv_cnt - fv0);
        end
        step(4'b0010, P2, 8);
        step(4'b0000, 8'h00, 8);
        tests++;
        if (fv_cnt - fv0 !== 1 || bcd_out !== 16'h6725) begin
            fails++; $display("FAIL multihot_frame got pulses=%0d bcd=%h want 1 6725", fv_cnt - fv0, bcd_out);
        end
    endtask

    task automatic test_long_hold;
        int fv0;
        fv0 = fv_cnt;
        step(4'b0001, P9, 100);
        tests++;
        if (fv_cnt - fv0 !== 0 || bcd_out[3:0] !== 4'd9) begin
            fails++; $display("FAIL long_hold got pulses=%0d nib0=%h want 0 9", fv_cnt - fv0, bcd_out[3:0]);
        end
        step(4'b0010, P8, 8);
        step(4'b0100, P7, 8);
        step(4'b1000, P6, 8);
        tests++;
        if (fv_cnt - fv0 !== 1 || bcd_out !== 16'h6789) begin
            fails++; $display("FAIL long_hold_frame got pulses=%0d bcd=%h want 1 6789", fv_cnt - fv0, bcd_out);
        end
        fv0 = fv_cnt;
        for (int r = 0; r < 2; r++) begin
            step(4'b0001, P0, 8);
            step(4'b0010, P1, 8);
            step(4'b0100, P2, 8);
            step(4'b1000, P3, 8);
        end
        step(4'b0000, 8'h00, 8);
        tests++;
        if (fv_cnt - fv0 !== 2 || bcd_out !== 16'h3210) begin
            fails++; $display("FAIL back_to_back got pulses=%0d bcd=%h want 2 3210", fv_cnt - fv0, bcd_out);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_scan();
        test_glitch();
        test_invalid();
        test_multihot();
        test_long_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
